// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types and constants for the OTTER memory subsystem
//
// Contents:
//   WORD_W      : memory word width in bits
//   mem_op_t    : line-transfer operation codes (code 3 is reserved)
//   cla_state_t : cache_line_burst_adapter FSM states
package otter_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_WB_FILL = 2'd2
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WB_BURST = 3'd1,
    ST_WB_GAP   = 3'd2,
    ST_RD_BURST = 3'd3,
    ST_RD_GAP   = 3'd4,
    ST_DONE     = 3'd5
  } cla_state_t;

endpackage

// File: rtl/cache_line_burst_adapter.sv
// rtl/cache_line_burst_adapter.sv - cache line refill/writeback engine using fixed-length memory bursts
//
// Moves one cache line between the data cache controller and main memory as
// LINE_WORDS/BURST_LEN bursts. WB_FILL writes back the victim line and then
// refills the requested line under a single request/done handshake.
//
// Ports:
//   CLK, RST                  : clock (rising edge), async active-high reset
//   req_valid, req_op         : request strobe and operation (accepted only while ready)
//   req_line_addr             : line to refill (READ, WB_FILL) or to write (WRITE)
//   req_wb_addr               : victim line address (WB_FILL only)
//   req_wr_line               : line to write, word i at bits [32i+31:32i]
//   ready, done               : idle indication, one-cycle completion pulse
//   rd_line                   : refilled line, valid from done until the next accept
//   mem_re, mem_we            : memory read / write burst request
//   mem_addr, mem_din         : burst start byte address, write data of the current beat
//   mem_dout, mem_valid       : read data, one valid pulse per transferred beat
module cache_line_burst_adapter
  import otter_mem_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int BURST_LEN  = 4,
  parameter int ADDR_W     = 32,
  localparam int LA_W      = ADDR_W - $clog2(LINE_WORDS) - 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         req_valid,
  input  logic [1:0]                   req_op,
  input  logic [LA_W-1:0]              req_line_addr,
  input  logic [LA_W-1:0]              req_wb_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] req_wr_line,
  output logic                         ready,
  output logic                         done,
  output logic [WORD_W*LINE_WORDS-1:0] rd_line,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WORD_W-1:0]            mem_din,
  input  logic [WORD_W-1:0]            mem_dout,
  input  logic                         mem_valid
);

  localparam int LW_SH  = $clog2(LINE_WORDS);
  localparam int WIDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [WIDX_W-1:0] WIDX_BURST_MASK = ~(WIDX_W'(BURST_LEN - 1));

  cla_state_t                          r_state;
  mem_op_t                             r_op;
  logic [LA_W-1:0]                     r_act_addr;
  logic [LA_W-1:0]                     r_line_addr;
  logic [LINE_WORDS-1:0][WORD_W-1:0]   r_wr_line;
  logic [LINE_WORDS-1:0][WORD_W-1:0]   r_rd_line;
  logic [WIDX_W-1:0]                   r_widx;
  logic [BCNT_W-1:0]                   r_bcnt;
  logic                                r_ready;
  logic                                r_done;
  logic                                r_mem_re;
  logic                                r_mem_we;
  logic [ADDR_W-1:0]                   r_mem_addr;
  logic [WORD_W-1:0]                   r_mem_din;

  logic              w_last_beat;
  logic              w_last_word;
  logic [WIDX_W-1:0] w_widx_nxt;

  assign w_last_beat = (r_bcnt == BCNT_W'(BURST_LEN - 1));
  assign w_last_word = (r_widx == WIDX_W'(LINE_WORDS - 1));
  assign w_widx_nxt  = r_widx + 1'b1;

  assign ready    = r_ready;
  assign done     = r_done;
  assign rd_line  = r_rd_line;
  assign mem_re   = r_mem_re;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

  // Byte address of the burst containing word widx of the given line.
  function automatic logic [ADDR_W-1:0] f_burst_addr(input logic [LA_W-1:0]   line,
                                                     input logic [WIDX_W-1:0] widx);
    logic [WIDX_W-1:0] base;
    base = widx & WIDX_BURST_MASK;
    return (ADDR_W'(line) << (LW_SH + 2)) | (ADDR_W'(base) << 2);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_READ;
      r_act_addr  <= '0;
      r_line_addr <= '0;
      r_wr_line   <= '0;
      r_rd_line   <= '0;
      r_widx      <= '0;
      r_bcnt      <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          // Reserved op code 3 is dropped without a done pulse.
          if (req_valid && (req_op != 2'd3)) begin
            r_op        <= mem_op_t'(req_op);
            r_line_addr <= req_line_addr;
            r_wr_line   <= req_wr_line;
            r_widx      <= '0;
            r_bcnt      <= '0;
            r_ready     <= 1'b0;
            if (req_op == OP_READ) begin
              r_state    <= ST_RD_BURST;
              r_act_addr <= req_line_addr;
              r_mem_re   <= 1'b1;
              r_mem_addr <= f_burst_addr(req_line_addr, '0);
            end else begin
              // WRITE writes the requested line; WB_FILL writes the victim first.
              r_state    <= ST_WB_BURST;
              r_act_addr <= (req_op == OP_WRITE) ? req_line_addr : req_wb_addr;
              r_mem_we   <= 1'b1;
              r_mem_addr <= f_burst_addr((req_op == OP_WRITE) ? req_line_addr : req_wb_addr, '0);
              r_mem_din  <= req_wr_line[WORD_W-1:0];
            end
          end
        end

        ST_RD_BURST: begin
          if (mem_valid) begin
            r_rd_line[r_widx] <= mem_dout;
            r_widx            <= w_widx_nxt;
            if (w_last_beat) begin
              r_bcnt   <= '0;
              r_mem_re <= 1'b0;
              if (w_last_word) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_RD_GAP;
              end
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end

        ST_RD_GAP: begin
          // widx already points at the first word of the next burst.
          r_state    <= ST_RD_BURST;
          r_mem_re   <= 1'b1;
          r_mem_addr <= f_burst_addr(r_act_addr, r_widx);
        end

        ST_WB_BURST: begin
          if (mem_valid) begin
            r_widx    <= w_widx_nxt;
            r_mem_din <= r_wr_line[w_widx_nxt];
            if (w_last_beat) begin
              r_bcnt   <= '0;
              r_mem_we <= 1'b0;
              if (w_last_word) begin
                if (r_op == OP_WB_FILL) begin
                  // Write-to-read turnaround reuses the read gap state.
                  r_widx     <= '0;
                  r_act_addr <= r_line_addr;
                  r_state    <= ST_RD_GAP;
                end else begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end
              end else begin
                r_state <= ST_WB_GAP;
              end
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end

        ST_WB_GAP: begin
          r_state    <= ST_WB_BURST;
          r_mem_we   <= 1'b1;
          r_mem_addr <= f_burst_addr(r_act_addr, r_widx);
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_ready  <= 1'b1;
          r_done   <= 1'b0;
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_burst_adapter.sv
// tb/tb_cache_line_burst_adapter.sv - directed self-checking bench for cache_line_burst_adapter
module tb_cache_line_burst_adapter;
  import otter_mem_pkg::*;

  localparam int LA_W = 27;

  logic             CLK;
  logic             RST;
  logic             req_valid;
  logic [1:0]       req_op;
  logic [LA_W-1:0]  req_line_addr;
  logic [LA_W-1:0]  req_wb_addr;
  logic [255:0]     req_wr_line;
  logic             ready;
  logic             done;
  logic [255:0]     rd_line;
  logic             mem_re;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout;
  logic             mem_valid;

  logic             resp_valid;
  logic             spur_valid;
  logic             spur_en;
  logic [31:0]      rd_base;
  int               rd_idx;
  int               beat_cnt;

  assign mem_valid = resp_valid | spur_valid;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int done_cnt, done_cyc, last_beat_cyc, acc_cnt, both_cnt, re_cyc, we_cyc, addr_chg, low_run;
  logic seen_burst, prev_act;
  logic [31:0] prev_addr;

  // Log 0: burst start {we, addr[30:0]}; log 1: written data per beat; log 2: gap lengths.
  logic [31:0] lg [0:2][0:15];
  int          n_lg [0:2];

  cache_line_burst_adapter #(
    .LINE_WORDS(8),
    .BURST_LEN (4),
    .ADDR_W    (32)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_line_addr(req_line_addr),
    .req_wb_addr  (req_wb_addr),
    .req_wr_line  (req_wr_line),
    .ready        (ready),
    .done         (done),
    .rd_line      (rd_line),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_valid    (mem_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic void lg_push(input int k, input logic [31:0] v);
    if (n_lg[k] < 16) begin
      lg[k][n_lg[k]] = v;
      n_lg[k]++;
    end
  endfunction

  function automatic logic [255:0] lg_pack(input int k);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i < n_lg[k]) r[i*32 +: 32] = lg[k][i];
    return r;
  endfunction

  function automatic logic [255:0] seq_line(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + step * i;
    return r;
  endfunction

  task automatic clr();
    for (int k = 0; k < 3; k++) n_lg[k] = 0;
    done_cnt = 0; acc_cnt = 0; both_cnt = 0; re_cyc = 0; we_cyc = 0; addr_chg = 0;
    rd_idx = 0; beat_cnt = 0; last_beat_cyc = -1; done_cyc = -100;
  endtask

  // Bus monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      prev_act   = 1'b0;
      seen_burst = 1'b0;
      low_run    = 0;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (mem_valid && (mem_re || mem_we)) last_beat_cyc = cyc;
      if (mem_re && mem_we) both_cnt++;
      if (mem_re) re_cyc++;
      if (mem_we) we_cyc++;
      if (ready && req_valid && req_op != 2'd3) acc_cnt++;
      if (mem_re || mem_we) begin
        if (!prev_act) begin
          lg_push(0, {mem_we, mem_addr[30:0]});
          if (seen_burst) lg_push(2, low_run);
          seen_burst = 1'b1;
          low_run    = 0;
        end else if (mem_addr != prev_addr) begin
          addr_chg++;
        end
      end else if (ready) begin
        seen_burst = 1'b0;
        low_run    = 0;
      end else begin
        low_run++;
      end
      prev_act  = mem_re || mem_we;
      prev_addr = mem_addr;
    end
    cyc++;
  end

  // Memory model: ~10 cycles from request to first beat, then one beat per cycle.
  initial begin
    resp_valid = 1'b0;
    mem_dout   = '0;
    forever begin
      tick();
      resp_valid = 1'b0;
      if (!RST && (mem_re || mem_we)) begin
        repeat (9) tick();
        for (int b = 0; b < 4; b++) begin
          if (RST) break;
          resp_valid = 1'b1;
          if (mem_we) lg_push(1, mem_din);
          else begin
            mem_dout = rd_base + rd_idx;
            rd_idx++;
          end
          beat_cnt++;
          tick();
        end
        resp_valid = 1'b0;
      end
    end
  end

  // Spurious beats while the bus is idle inside an operation (gaps and DONE).
  initial begin
    spur_valid = 1'b0;
    forever begin
      tick();
      spur_valid = spur_en && !RST && !ready && !mem_re && !mem_we;
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [LA_W-1:0] la,
                          input logic [LA_W-1:0] wa, input logic [255:0] wl);
    tick();
    req_op        = op;
    req_line_addr = la;
    req_wb_addr   = wa;
    req_wr_line   = wl;
    req_valid     = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != 0, 1'b1);
    repeat (3) tick();
  endtask

  logic [255:0] e;

  initial begin
    RST = 1'b1;
    req_valid = 1'b0; req_op = 2'd0; req_line_addr = '0; req_wb_addr = '0; req_wr_line = '0;
    spur_en = 1'b0; rd_base = '0;
    clr();
    repeat (3) @(negedge CLK);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_re_we", {mem_re, mem_we}, 2'b00);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_din", mem_din, 32'h0);
    check("rst_rd_line", rd_line, 256'h0);
    tick();
    RST = 1'b0;
    repeat (2) tick();

    // READ line 0x10
    clr(); rd_base = 32'hA0;
    start_op(2'd0, 27'h10, 27'h0, '0);
    check("rd_lat_re", {ready, mem_re, mem_we}, 3'b010);
    check("rd_lat_addr", mem_addr, 32'h200);
    wait_done("rd");
    check("rd_line", rd_line, seq_line(32'hA0, 32'h1));
    check("rd_nbursts", n_lg[0], 2);
    e = '0; e[31:0] = 32'h200; e[63:32] = 32'h210;
    check("rd_addrs", lg_pack(0), e);
    check("rd_ngaps", n_lg[2], 1);
    check("rd_gap_len", lg_pack(2), 256'h1);
    check("rd_done_cnt", done_cnt, 1);
    check("rd_done_lat", done_cyc, last_beat_cyc + 1);
    check("rd_no_we", we_cyc, 0);
    check("rd_addr_hold", addr_chg, 0);
    check("rd_ready_back", ready, 1'b1);

    // WRITE line 0x3
    clr();
    start_op(2'd1, 27'h3, 27'h0, seq_line(32'h11, 32'h11));
    check("wr_lat", {mem_re, mem_we, mem_din}, {2'b01, 32'h11});
    check("wr_lat_addr", mem_addr, 32'h60);
    wait_done("wr");
    check("wr_din_seq", lg_pack(1), seq_line(32'h11, 32'h11));
    check("wr_nbeats", n_lg[1], 8);
    e = '0; e[31:0] = 32'h8000_0060; e[63:32] = 32'h8000_0070;
    check("wr_addrs", lg_pack(0), e);
    check("wr_no_re", re_cyc, 0);
    check("wr_done_cnt", done_cnt, 1);
    check("wr_done_lat", done_cyc, last_beat_cyc + 1);
    check("wr_gap_len", lg_pack(2), 256'h1);

    // WB_FILL: victim 0x5, refill 0x9
    clr(); rd_base = 32'hC0;
    start_op(2'd2, 27'h9, 27'h5, seq_line(32'h1000, 32'h1));
    check("wbf_lat", {mem_re, mem_we}, 2'b01);
    check("wbf_lat_addr", mem_addr, 32'hA0);
    wait_done("wbf");
    e = '0;
    e[31:0] = 32'h8000_00A0; e[63:32] = 32'h8000_00B0; e[95:64] = 32'h120; e[127:96] = 32'h130;
    check("wbf_addrs", lg_pack(0), e);
    check("wbf_nbursts", n_lg[0], 4);
    e = '0; e[31:0] = 32'h1; e[63:32] = 32'h1; e[95:64] = 32'h1;
    check("wbf_gaps", lg_pack(2), e);
    check("wbf_ngaps", n_lg[2], 3);
    check("wbf_din_seq", lg_pack(1), seq_line(32'h1000, 32'h1));
    check("wbf_rd_line", rd_line, seq_line(32'hC0, 32'h1));
    check("wbf_done_cnt", done_cnt, 1);
    check("wbf_done_lat", done_cyc, last_beat_cyc + 1);
    check("wbf_both_high", both_cnt, 0);

    // Reserved op is ignored
    clr();
    start_op(2'd3, 27'h7, 27'h0, '0);
    check("rsv_idle", {ready, mem_re, mem_we}, 3'b100);
    repeat (5) tick();
    check("rsv_no_done", done_cnt, 0);
    check("rsv_still_idle", {ready, mem_re, mem_we}, 3'b100);

    // Robustness: req_valid held high, spurious beats in gaps and DONE
    clr(); rd_base = 32'hB0; spur_en = 1'b1;
    tick();
    req_op = 2'd0; req_line_addr = 27'h10; req_valid = 1'b1;
    tick();
    req_line_addr = 27'h20;
    for (int n = 0; n < 400; n++) begin
      if (done) break;
      tick();
    end
    req_valid = 1'b0;
    repeat (3) tick();
    spur_en = 1'b0;
    check("rob_accepts", acc_cnt, 1);
    check("rob_done_cnt", done_cnt, 1);
    check("rob_rd_line", rd_line, seq_line(32'hB0, 32'h1));
    e = '0; e[31:0] = 32'h200; e[63:32] = 32'h210;
    check("rob_addrs", lg_pack(0), e);
    check("rob_nbursts", n_lg[0], 2);

    // Reset after 3 read beats
    clr(); rd_base = 32'hD0;
    start_op(2'd0, 27'h10, 27'h0, '0);
    for (int n = 0; n < 100 && beat_cnt < 3; n++) @(negedge CLK);
    @(posedge CLK);
    #2;
    check("mid_partial", rd_line[95:0], {32'hD2, 32'hD1, 32'hD0});
    check("mid_re_before", mem_re, 1'b1);
    #1;
    RST = 1'b1;
    #1;
    check("mid_rst_re", mem_re, 1'b0);
    check("mid_rst_rd_line", rd_line, 256'h0);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_addr", mem_addr, 32'h0);
    repeat (3) tick();
    RST = 1'b0;
    repeat (4) tick();
    check("mid_no_done", done_cnt, 0);
    check("mid_idle", {ready, mem_re, mem_we}, 3'b100);

    clr(); rd_base = 32'hE0;
    start_op(2'd0, 27'h10, 27'h0, '0);
    wait_done("post");
    check("post_rd_line", rd_line, seq_line(32'hE0, 32'h1));
    check("post_done_cnt", done_cnt, 1);
    check("post_nbursts", n_lg[0], 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
